// File: rtl/song_seq_pkg.sv
// Shared constants for the song sequencer: end-of-song modes, LFSR seed/taps, width helper.
package song_seq_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_LOOP_ALL   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_REPEAT_ONE = 2'd1;
  localparam logic [MODE_W-1:0] MODE_ONCE       = 2'd2;
  localparam logic [MODE_W-1:0] MODE_SHUFFLE    = 2'd3;

  // Galois right-shift form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic int seq_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dffr.sv
// Plain D flop with synchronous active-high reset to a parameterised value.
module dffr #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR; steps every clock, reloads the seed on reset.
module lfsr8
  import song_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);

  logic [7:0] value_d;

  assign value_d = {1'b0, value[7:1]} ^ ({8{value[0]}} & LFSR_TAPS);

  dffr #(.W(8), .RST_VAL(LFSR_SEED)) u_state (
    .clk   (clk),
    .reset (reset),
    .d     (value_d),
    .q     (value)
  );

endmodule

// File: rtl/song_sequencer.sv
// Playback control: song select, play/pause, end-of-song modes, restart strobe.
// Optional shuffle mode and LFSR built only when SONG_SEQ_SHUFFLE_EN is defined.
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = seq_clog2(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              mode_button,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic [MODE_W-1:0] mode
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  logic [SONG_W-1:0] song_d, song_inc, song_dec, shuffle_pick;
  logic [MODE_W-1:0] mode_d, mode_step;
  logic              play_d, reset_player_d, shuffle_on;

  assign song_inc   = (song == LAST_SONG) ? '0 : song + SONG_W'(1);
  assign song_dec   = (song == '0) ? LAST_SONG : song - SONG_W'(1);
  assign shuffle_on = (mode == MODE_SHUFFLE);

`ifdef SONG_SEQ_SHUFFLE_EN
  logic [7:0]        lfsr_value;
  logic [7:0]        pick_mod;
  logic [SONG_W-1:0] pick_raw;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  assign pick_mod = lfsr_value % 8'(NUM_SONGS);
  assign pick_raw = SONG_W'(pick_mod);
  // Bump a pick that collides with the current song so it never repeats back-to-back.
  assign shuffle_pick = (pick_raw != song) ? pick_raw :
                        (pick_raw == LAST_SONG) ? '0 : pick_raw + SONG_W'(1);
  assign mode_step    = mode + MODE_W'(1);
`else
  assign shuffle_pick = song_inc;
  assign mode_step    = (mode == MODE_ONCE) ? MODE_LOOP_ALL : mode + MODE_W'(1);
`endif

  assign mode_d = mode_button ? mode_step : mode;

  // Transport events: only the highest-priority one acts in a cycle.
  always_comb begin
    song_d         = song;
    play_d         = play;
    reset_player_d = 1'b0;
    if (play_button) begin
      play_d = ~play;
    end else if (prev_button) begin
      song_d         = song_dec;
      reset_player_d = 1'b1;
    end else if (next_button) begin
      song_d         = shuffle_on ? shuffle_pick : song_inc;
      reset_player_d = 1'b1;
    end else if (song_done && play) begin
      reset_player_d = 1'b1;
      case (mode)
        MODE_REPEAT_ONE: song_d = song;
        MODE_ONCE: begin
          if (song == LAST_SONG) begin
            song_d = '0;
            play_d = 1'b0;
          end else begin
            song_d = song_inc;
          end
        end
        MODE_SHUFFLE: song_d = shuffle_pick;
        default:      song_d = song_inc;
      endcase
    end
  end

  dffr #(.W(SONG_W), .RST_VAL('0)) u_song (
    .clk (clk), .reset (reset), .d (song_d), .q (song)
  );

  dffr #(.W(1), .RST_VAL(1'b0)) u_play (
    .clk (clk), .reset (reset), .d (play_d), .q (play)
  );

  dffr #(.W(MODE_W), .RST_VAL(MODE_LOOP_ALL)) u_mode (
    .clk (clk), .reset (reset), .d (mode_d), .q (mode)
  );

  dffr #(.W(1), .RST_VAL(1'b1)) u_reset_player (
    .clk (clk), .reset (reset), .d (reset_player_d), .q (reset_player)
  );

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer (NUM_SONGS=5) against a behavioural playback model.
// Shuffle checks are active when SONG_SEQ_SHUFFLE_EN is defined.
module tb_song_sequencer;

  localparam int N = 5;
  localparam int W = 3;
`ifdef SONG_SEQ_SHUFFLE_EN
  localparam int NMODES = 4;
`else
  localparam int NMODES = 3;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic play_button = 1'b0, next_button = 1'b0, prev_button = 1'b0;
  logic mode_button = 1'b0, song_done = 1'b0;
  logic         play, reset_player;
  logic [W-1:0] song;
  logic [1:0]   mode;

  always #5 clk = ~clk;

  song_sequencer #(.NUM_SONGS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .prev_button  (prev_button),
    .mode_button  (mode_button),
    .song_done    (song_done),
    .play         (play),
    .reset_player (reset_player),
    .song         (song),
    .mode         (mode)
  );

  // scoreboard
  int n_compared = 0;
  int n_mismatched = 0;
  int exp_song = 0, exp_play = 0, exp_mode = 0, exp_rp = 1, exp_lfsr = 'hA5;

  task automatic check_eq(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int shuffle_pick_model(input int s, input int l);
    int p;
    p = l % N;
    return (p == s) ? (p + 1) % N : p;
  endfunction

  // driver: apply one cycle of inputs, advance the model, compare all outputs
  task automatic cycle(input bit r, input bit pb, input bit nb, input bit pvb,
                       input bit mb, input bit sd);
    int ns, np, nm, nrp, nl;
    reset = r; play_button = pb; next_button = nb; prev_button = pvb;
    mode_button = mb; song_done = sd;
    if (r) begin
      ns = 0; np = 0; nm = 0; nrp = 1; nl = 'hA5;
    end else begin
      nl  = (exp_lfsr >> 1) ^ (((exp_lfsr & 1) != 0) ? 'hB8 : 0);
      nm  = mb ? (exp_mode + 1) % NMODES : exp_mode;
      ns  = exp_song; np = exp_play; nrp = 0;
      if (pb) np = 1 - exp_play;
      else if (pvb) begin ns = (exp_song + N - 1) % N; nrp = 1; end
      else if (nb) begin
        ns  = (exp_mode == 3) ? shuffle_pick_model(exp_song, exp_lfsr) : (exp_song + 1) % N;
        nrp = 1;
      end else if (sd && exp_play == 1) begin
        nrp = 1;
        if (exp_mode == 0) ns = (exp_song + 1) % N;
        else if (exp_mode == 2) begin
          if (exp_song == N - 1) begin ns = 0; np = 0; end
          else ns = exp_song + 1;
        end else if (exp_mode == 3) ns = shuffle_pick_model(exp_song, exp_lfsr);
      end
    end
    @(posedge clk);
    #1;
    exp_song = ns; exp_play = np; exp_mode = nm; exp_rp = nrp; exp_lfsr = nl;
    check_eq("song", int'(song), exp_song);
    check_eq("play", int'(play), exp_play);
    check_eq("mode", int'(mode), exp_mode);
    check_eq("reset_player", int'(reset_player), exp_rp);
    reset = 1'b0; play_button = 1'b0; next_button = 1'b0; prev_button = 1'b0;
    mode_button = 1'b0; song_done = 1'b0;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int prev_song;
    int hits[N];

    // reset for 2 cycles, then play
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check_eq("reset_song_const", int'(song), 0);
    check_eq("reset_rp_const", int'(reset_player), 1);
    cycle(0, 1, 0, 0, 0, 0);
    check_eq("play_after_pulse", int'(play), 1);
    check_eq("rp_after_play", int'(reset_player), 0);

    // wrap around the top and bottom of the song list
    for (int i = 0; i < N - 1; i++) cycle(0, 0, 1, 0, 0, 0);
    check_eq("at_last_song", int'(song), N - 1);
    cycle(0, 0, 1, 0, 0, 0);
    check_eq("next_wrap", int'(song), 0);
    check_eq("next_wrap_rp", int'(reset_player), 1);
    idle();
    check_eq("rp_single_cycle", int'(reset_player), 0);
    cycle(0, 0, 0, 1, 0, 0);
    check_eq("prev_wrap", int'(song), N - 1);
    check_eq("prev_keeps_play", int'(play), 1);

    // priority: play beats next and song_done
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 1);
    check_eq("prio_song", int'(song), 2);
    check_eq("prio_play", int'(play), 0);
    check_eq("prio_rp", int'(reset_player), 0);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("paused_done_song", int'(song), 2);

    // REPEAT_ONE at song 1
    cycle(0, 1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("repeat_song", int'(song), 1);
    check_eq("repeat_rp", int'(reset_player), 1);

    // ONCE at the last song stops and rewinds
    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < N - 2; i++) cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("once_song", int'(song), 0);
    check_eq("once_play", int'(play), 0);

    // LOOP_ALL at the last song keeps playing
    for (int i = 0; i < NMODES && exp_mode != 0; i++) cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("loop_song", int'(song), 0);
    check_eq("loop_play", int'(play), 1);

    // mode cycling from 0
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0);
`ifdef SONG_SEQ_SHUFFLE_EN
    check_eq("mode_after_4", int'(mode), 0);
`else
    check_eq("mode_after_4", int'(mode), 1);
`endif

`ifdef SONG_SEQ_SHUFFLE_EN
    // shuffle: no back-to-back repeat, full coverage
    for (int i = 0; i < NMODES && exp_mode != 3; i++) cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < N; i++) hits[i] = 0;
    for (int i = 0; i < 200; i++) begin
      prev_song = int'(song);
      cycle(0, 0, 0, 0, 0, 1);
      check_eq("shuffle_norepeat", int'(int'(song) != prev_song), 1);
      if (int'(song) < N) hits[int'(song)]++;
    end
    for (int i = 0; i < N; i++) check_eq("shuffle_hit", int'(hits[i] > 0), 1);
`else
    prev_song = 0;
    for (int i = 0; i < N; i++) hits[i] = 0;
`endif

    // random traffic including mid-run resets
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Parametrised playback control unit for the music synth. It selects one of NUM_SONGS songs and toggles play/pause. It issues a one-cycle reset_player pulse on every song change or restart. It supports previous/next navigation and selectable end-of-song modes. It sits between the debounced/one-pulsed front-panel buttons and the song player / note sequencer.

Parameters:
NUM_SONGS, 4, number of songs selectable; must be at least 2; need not be a power of two.
SONG_W, clog2(NUM_SONGS) with a minimum of 1, width of the song index.

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
play_button  input  1  one-cycle pulse; toggles play/pause
next_button  input  1  one-cycle pulse; advance to the next song
prev_button  input  1  one-cycle pulse; go back to the previous song
mode_button  input  1  one-cycle pulse; cycle the end-of-song mode
song_done  input  1  one-cycle pulse from the player at the end of the current song
play  output  1  1 = player running
reset_player  output  1  registered one-cycle restart strobe to the player
song  output  SONG_W  current song index, 0..NUM_SONGS-1
mode  output  2  current end-of-song mode

Behaviour:
- All outputs are registered; a decision made in cycle N is visible in cycle N+1.
- Reset values, while reset is high and in the first cycle after it: song=0, play=0, mode=LOOP_ALL (2'd0), reset_player=1.
- Modes:
  - LOOP_ALL = 0
  - REPEAT_ONE = 1
  - ONCE = 2
  - SHUFFLE = 3, only with SHUFFLE_EN.
- mode_button steps 0→1→2→0. With SHUFFLE_EN it steps 0→1→2→3→0.
- The mode update runs in parallel with all other events. It affects song_done handling from the next cycle onward.
- Transport priority in one cycle is play_button > prev_button > next_button > song_done. Only the highest-priority event acts; the others are dropped and not queued.
- play_button: play <= ~play. song is unchanged and reset_player=0.
- next_button: song <= song+1, wrapping NUM_SONGS-1 → 0. The play state is preserved. reset_player pulses.
- prev_button: song <= song-1, wrapping 0 → NUM_SONGS-1. The play state is preserved. reset_player pulses.
- song_done is ignored when play=0. When play=1:
  - LOOP_ALL: song advances with wrap; play stays 1; reset_player pulses.
  - REPEAT_ONE: song is unchanged; play stays 1; reset_player pulses (restart).
  - ONCE: if song==NUM_SONGS-1, then song <= 0, play <= 0, and reset_player pulses. Otherwise song advances, play stays 1, and reset_player pulses.
  - SHUFFLE: song <= shuffle pick (see Optional Feature); play stays 1; reset_player pulses.
- reset_player is high for exactly one cycle per accepted song change or restart. It is 0 at all other times except during reset.
- Idle cycles hold all state.
- Reset asserted mid-operation overrides every input in that cycle.

Optional Feature:
SONG_SEQ_SHUFFLE_EN
- Defined:
  - adds mode SHUFFLE (3) and an 8-bit Galois LFSR;
  - the LFSR uses taps x^8+x^6+x^5+x^4+1 and seed 8'hA5 on reset;
  - the LFSR steps every clock.
  - Shuffle pick p = lfsr mod NUM_SONGS. If p == song, the pick is p+1 with wrap, so the same song never repeats back-to-back.
  - next_button in SHUFFLE mode also uses the shuffle pick; prev_button stays sequential.
- Undefined:
  - no LFSR logic is built;
  - mode never takes value 3 and wraps 2→0.

Decomposition:
- Package song_seq_pkg holds:
  - the mode constants MODE_LOOP_ALL, MODE_REPEAT_ONE, MODE_ONCE, MODE_SHUFFLE;
  - the mode width constant (2);
  - the clog2 helper function;
  - the LFSR seed and tap constants.
- One sub-module, lfsr8, is instantiated only under SONG_SEQ_SHUFFLE_EN. State registers use the existing dffr flop cells.

Test Plan:
- Reset and play: assert reset for 2 cycles, then pulse play_button → song=0, play=0, reset_player=1 during reset; one cycle after the pulse play=1 and reset_player=0.
- Wrap with NUM_SONGS=5: from song=4, pulse next → song=0 with a single-cycle reset_player. From song=0, pulse prev → song=4. play is unchanged in both cases.
- Priority: play_button, next_button and song_done in the same cycle with play=1, song=2 → play=0, song=2, no reset_player. Pulse song_done while paused → no change.
- Modes with play=1: REPEAT_ONE song_done at song=1 → song=1, reset_player pulse. ONCE song_done at song=3 (NUM_SONGS=4) → song=0, play=0. LOOP_ALL at song=3 → song=0, play=1.
- Mode cycling: 4 mode_button pulses without the macro → 1,2,0,1. The same with the macro → 1,2,3,0.
- SHUFFLE_EN: in mode 3, 200 consecutive song_done pulses → song never equals the previous song, and every index 0..NUM_SONGS-1 is hit at least once.
